// File: rtl/prog_imem_pkg.sv
// Shared types and constants for the program instruction memory.
// The state enum and the default no-op word live here so the bench and other blocks agree on them.
package prog_imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // True when a word address falls inside the populated part of the array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/prog_instr_mem_if.sv
// Load/fetch bus of the program instruction memory.
// master drives loads and fetches; slave is the memory itself.
interface prog_instr_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              busy;
    logic [ADDR_W:0]   load_count;
    logic              load_overflow;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        input  load_ready, fetch_valid, fetch_data, busy, load_count, load_overflow
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        output load_ready, fetch_valid, fetch_data, busy, load_count, load_overflow
    );
endinterface

// File: rtl/imem_ram.sv
// Instruction storage: one write port and one registered read port.
// The array carries no reset; its contents are initialised by the owner writing them.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/prog_instr_mem.sv
// Program instruction memory: clears itself to NOP after reset, accepts streamed program
// loads, and serves single-cycle-latency instruction fetches while running.
module prog_instr_mem
    import prog_imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    prog_instr_mem_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    imem_state_t       state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   load_count;
    logic              load_overflow;
    logic              busy;
    logic              load_ready;

    logic              fetch_ok_p0;
    logic              oor_p0;
    logic              vld_p1;
    logic              rd_seen_p1;
    logic              rd_oor_p1;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Stage p0: fetch request qualified by state, address checked against the array size
    assign fetch_ok_p0 = (state == RUN) && bus.fetch_req;
    assign oor_p0      = !addr_in_range(32'(bus.fetch_addr), DEPTH);

    // CLEAR and LOAD never overlap, so they share the single write port
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wptr;
        ram_wdata = bus.load_data;
        case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr;
                ram_wdata = NOP_WORD;
            end
            LOAD: begin
                ram_we = bus.load_valid;
            end
            default: ;
        endcase
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (fetch_ok_p0 && !oor_p0),
        .raddr (bus.fetch_addr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= CLEAR;
            clr_ptr       <= '0;
            wptr          <= '0;
            load_count    <= '0;
            load_overflow <= 1'b0;
            busy          <= 1'b1;
            load_ready    <= 1'b0;
            vld_p1        <= 1'b0;
            rd_seen_p1    <= 1'b0;
            rd_oor_p1     <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == LAST_ADDR) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // Stage p1: result of the accepted fetch presented
                    if (bus.fetch_req) begin
                        vld_p1     <= 1'b1;
                        rd_seen_p1 <= 1'b1;
                        rd_oor_p1  <= oor_p0;
                    end
                    if (bus.load_start) begin
                        state         <= LOAD;
                        wptr          <= '0;
                        load_count    <= '0;
                        load_overflow <= 1'b0;
                        busy          <= 1'b1;
                        load_ready    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.load_valid) begin
                        wptr       <= wptr + ADDR_W'(1);
                        load_count <= load_count + (ADDR_W+1)'(1);
                        // A load that fills the last word without ending is cut short and flagged
                        if (bus.load_last || (wptr == LAST_ADDR)) begin
                            state      <= RUN;
                            busy       <= 1'b0;
                            load_ready <= 1'b0;
                            if (!bus.load_last) begin
                                load_overflow <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state      <= CLEAR;
                    clr_ptr    <= '0;
                    busy       <= 1'b1;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_valid   = vld_p1;
    assign bus.fetch_data    = (rd_seen_p1 && !rd_oor_p1) ? ram_rdata : NOP_WORD;
    assign bus.busy          = busy;
    assign bus.load_ready    = load_ready;
    assign bus.load_count    = load_count;
    assign bus.load_overflow = load_overflow;

endmodule

// File: tb/tb_prog_instr_mem.sv
// Bench for prog_instr_mem: three instances (depth 256, 16, 200) share one stimulus stream
// and are each compared every cycle against a behavioural model of the memory.
`timescale 1ns/1ps
module tb_prog_instr_mem;
    localparam int DW = 32;
    localparam int AW = 8;

    bit             clk;
    logic           rst = 1'b0;
    logic           load_start, load_valid, load_last, fetch_req;
    logic [DW-1:0]  load_data;
    logic [AW-1:0]  fetch_addr;

    logic           busy_o  [3];
    logic           ready_o [3];
    logic           fv_o    [3];
    logic           ovf_o   [3];
    logic [DW-1:0]  fd_o    [3];
    logic [AW:0]    cnt_o   [3];

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    logic [31:0] w [4] = '{32'hAC410000, 32'h8C850000, 32'h10A10001, 32'h08000001};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        prog_instr_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.load_start = load_start;
        assign bus.load_valid = load_valid;
        assign bus.load_data  = load_data;
        assign bus.load_last  = load_last;
        assign bus.fetch_req  = fetch_req;
        assign bus.fetch_addr = fetch_addr;
        prog_instr_mem #(
            .DATA_W   (DW),
            .ADDR_W   (AW),
            .DEPTH    (g == 0 ? 256 : (g == 1 ? 16 : 200)),
            .NOP_WORD (g == 0 ? 32'h0000_0000 : (g == 1 ? 32'h0000_0013 : 32'hDEAD_BEEF))
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign busy_o[g]  = bus.busy;
        assign ready_o[g] = bus.load_ready;
        assign fv_o[g]    = bus.fetch_valid;
        assign fd_o[g]    = bus.fetch_data;
        assign cnt_o[g]   = bus.load_count;
        assign ovf_o[g]   = bus.load_overflow;
    end

    function automatic int depth_of(input int g);
        return (g == 0) ? 256 : ((g == 1) ? 16 : 200);
    endfunction

    function automatic logic [31:0] nop_of(input int g);
        return (g == 0) ? 32'h0000_0000 : ((g == 1) ? 32'h0000_0013 : 32'hDEAD_BEEF);
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d: got %h expected %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: words still to clear, a loading flag, and words written so far.
    logic [31:0] m_mem [3][256];
    int          clear_left [3];
    int          e_cnt      [3];
    bit          loading    [3];
    bit          e_fv       [3];
    bit          e_ovf      [3];
    logic [31:0] e_fd       [3];

    initial forever begin
        @(posedge clk or negedge rst);
        for (int g = 0; g < 3; g++) begin
            if (!rst) begin
                clear_left[g] = depth_of(g);
                loading[g]    = 0;
                e_fv[g]       = 0;
                e_fd[g]       = nop_of(g);
                e_cnt[g]      = 0;
                e_ovf[g]      = 0;
            end else if (clear_left[g] > 0) begin
                m_mem[g][depth_of(g) - clear_left[g]] = nop_of(g);
                clear_left[g]--;
                e_fv[g] = 0;
            end else if (!loading[g]) begin
                e_fv[g] = fetch_req;
                if (fetch_req)
                    e_fd[g] = (int'(fetch_addr) < depth_of(g)) ? m_mem[g][fetch_addr] : nop_of(g);
                if (load_start) begin
                    loading[g] = 1;
                    e_cnt[g]   = 0;
                    e_ovf[g]   = 0;
                end
            end else begin
                e_fv[g] = 0;
                if (load_valid) begin
                    m_mem[g][e_cnt[g]] = load_data;
                    e_cnt[g]++;
                    if (load_last) loading[g] = 0;
                    else if (e_cnt[g] == depth_of(g)) begin
                        loading[g] = 0;
                        e_ovf[g]   = 1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            for (int g = 0; g < 3; g++) begin
                chk("busy", g, 32'(busy_o[g]), 32'(clear_left[g] > 0 || loading[g]));
                chk("load_ready", g, 32'(ready_o[g]), 32'(clear_left[g] == 0 && loading[g]));
                chk("fetch_valid", g, 32'(fv_o[g]), 32'(e_fv[g]));
                chk("fetch_data", g, fd_o[g], e_fd[g]);
                chk("load_count", g, 32'(cnt_o[g]), e_cnt[g]);
                chk("load_overflow", g, 32'(ovf_o[g]), 32'(e_ovf[g]));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < 600) begin
            tick();
            n++;
        end
        chk("idle_bound", 0, 32'(busy_o[0] || busy_o[1] || busy_o[2]), 0);
    endtask

    initial begin
        int fall [3];
        load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_req = 0; fetch_addr = '0;
        tick(); armed = 1; tick();
        rst = 1;
        fall = '{0, 0, 0};
        for (int n = 1; n <= 300; n++) begin
            tick();
            for (int g = 0; g < 3; g++)
                if (fall[g] == 0 && busy_o[g] === 1'b0) fall[g] = n;
        end
        chk("clear_cycles", 0, fall[0], 256);
        chk("clear_cycles", 1, fall[1], 16);
        chk("clear_cycles", 2, fall[2], 200);

        // Fetches after clearing, including out-of-range addresses
        fetch_req = 1; fetch_addr = 0; tick();
        chk("fetch_a0", 0, fd_o[0], 0);
        chk("fv_a0", 0, 32'(fv_o[0]), 1);
        fetch_addr = 5; tick();
        chk("fetch_a5", 0, fd_o[0], 0);
        chk("fetch_a5", 1, fd_o[1], 32'h13);
        fetch_addr = 255; tick();
        chk("fetch_a255", 0, fd_o[0], 0);
        chk("fetch_a255_oor", 2, fd_o[2], 32'hDEADBEEF);
        fetch_addr = 220; tick();
        chk("fetch_a220_oor", 2, fd_o[2], 32'hDEADBEEF);
        chk("fv_a220_oor", 2, 32'(fv_o[2]), 1);
        fetch_req = 0; tick();
        chk("fv_idle", 0, 32'(fv_o[0]), 0);

        // Four-word program, read back starting on the first RUN cycle
        load_start = 1; tick(); load_start = 0;
        for (int k = 0; k < 4; k++) begin
            chk("ready_in_load", 0, 32'(ready_o[0]), 1);
            load_valid = 1; load_data = w[k]; load_last = (k == 3); tick();
        end
        load_valid = 0; load_last = 0;
        chk("load_count4", 0, 32'(cnt_o[0]), 4);
        chk("busy_after_load", 0, 32'(busy_o[0]), 0);
        fetch_req = 1;
        for (int k = 0; k < 4; k++) begin
            fetch_addr = AW'(k); tick();
            chk("fetch_loaded", 0, fd_o[0], w[k]);
            chk("fv_loaded", 0, 32'(fv_o[0]), 1);
        end
        fetch_req = 0; tick();

        // Gaps in load_valid and fetches ignored while loading
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_data = 32'hA5A50001; tick();
        load_valid = 0; fetch_req = 1; fetch_addr = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fv_in_load", 0, 32'(fv_o[0]), 0);
            chk("fd_hold", 0, fd_o[0], w[3]);
            chk("cnt_in_gap", 0, 32'(cnt_o[0]), 1);
        end
        fetch_req = 0; load_valid = 1; load_data = 32'h5A5A0002; load_last = 1; tick();
        load_valid = 0; load_last = 0;
        chk("cnt_gap_load", 0, 32'(cnt_o[0]), 2);
        fetch_req = 1; fetch_addr = 0; tick();
        chk("gap_word0", 0, fd_o[0], 32'hA5A50001);
        fetch_addr = 1; tick();
        chk("gap_word1", 0, fd_o[0], 32'h5A5A0002);
        fetch_addr = 2; tick();
        chk("unwritten_kept", 0, fd_o[0], w[2]);
        fetch_req = 0; tick();

        // Overflow on the 16-deep instance
        load_start = 1; tick(); load_start = 0;
        for (int k = 0; k < 17; k++) begin
            if (k == 16) chk("ready_after_ovf", 1, 32'(ready_o[1]), 0);
            load_valid = 1; load_data = 32'(32'h100 + k); load_last = 0; tick();
            if (k == 15) begin
                chk("ovf_set", 1, 32'(ovf_o[1]), 1);
                chk("ovf_busy", 1, 32'(busy_o[1]), 0);
                chk("ovf_cnt", 1, 32'(cnt_o[1]), 16);
            end
        end
        chk("cnt_after_17", 1, 32'(cnt_o[1]), 16);
        chk("no_ovf_deep", 0, 32'(ovf_o[0]), 0);
        load_data = 32'h200; load_last = 1; tick();
        load_valid = 0; load_last = 0;
        chk("cnt18", 0, 32'(cnt_o[0]), 18);
        fetch_req = 1; fetch_addr = 15; tick();
        chk("ovf_word15", 1, fd_o[1], 32'h10F);
        fetch_addr = 16; tick();
        chk("deep_word16", 0, fd_o[0], 32'h110);
        chk("shallow_oor16", 1, fd_o[1], 32'h13);
        fetch_addr = 17; tick();
        chk("deep_word17", 0, fd_o[0], 32'h200);
        fetch_req = 0; tick();

        // Reset in the middle of a load
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_data = 32'h11111111; tick();
        load_data = 32'h22222222; tick();
        load_valid = 0;
        rst = 0; #1;
        chk("rst_busy", 0, 32'(busy_o[0]), 1);
        chk("rst_ready", 0, 32'(ready_o[0]), 0);
        chk("rst_fv", 0, 32'(fv_o[0]), 0);
        chk("rst_fd", 0, fd_o[0], 0);
        chk("rst_fd", 2, fd_o[2], 32'hDEADBEEF);
        chk("rst_cnt", 0, 32'(cnt_o[0]), 0);
        chk("rst_ovf", 1, 32'(ovf_o[1]), 0);
        tick(); rst = 1;
        wait_idle();
        fetch_req = 1; fetch_addr = 1; tick();
        chk("addr1_cleared", 0, fd_o[0], 0);
        fetch_req = 0; tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 999) < 3) begin
                rst = 0; tick(); rst = 1;
            end
            load_start = ($urandom_range(0, 99) < 6);
            load_valid = ($urandom_range(0, 99) < 70);
            load_last  = ($urandom_range(0, 99) < 12);
            load_data  = $urandom;
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 20)) : AW'($urandom_range(0, 255));
            tick();
        end
        load_start = 0; load_valid = 0; load_last = 0; fetch_req = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_instr_mem.md
PROG_INSTR_MEM -- requirements
Module: prog_instr_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, the fetch and load address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, the number of words stored (DEPTH <= 2**ADDR_W).
REQ-004 The block SHALL have parameter NOP_WORD, default 0, the word returned for an out-of-range fetch.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low.
REQ-007 load_start  in  1  one-cycle pulse requesting a program load.
REQ-008 load_valid  in  1  load word present.
REQ-009 load_data  in  DATA_W  load word.
REQ-010 load_last  in  1  marks the final word of the load.
REQ-011 load_ready  out  1  block accepts a load word this cycle.
REQ-012 fetch_req  in  1  fetch request.
REQ-013 fetch_addr  in  ADDR_W  word address of the fetch.
REQ-014 fetch_valid  out  1  fetch_data holds the result of the previous accepted request.
REQ-015 fetch_data  out  DATA_W  fetched instruction word.
REQ-016 busy  out  1  high in CLEAR or LOAD.
REQ-017 load_count  out  ADDR_W+1  number of words written by the last or current load.
REQ-018 load_overflow  out  1  sticky flag: a load ran past DEPTH words.

Function
REQ-019 The state machine SHALL have states CLEAR, RUN and LOAD.
REQ-020 CLEAR SHALL write NOP_WORD to address clr_ptr each cycle, from 0 to DEPTH-1, then enter RUN; clearing takes DEPTH cycles.
REQ-021 In RUN, a cycle with fetch_req=1 SHALL produce fetch_valid=1 on the next cycle, with fetch_data = mem[fetch_addr] (1-cycle latency, one result per request, back-to-back supported).
REQ-022 A fetch with fetch_addr >= DEPTH SHALL return NOP_WORD with fetch_valid=1.
REQ-023 fetch_req in CLEAR or LOAD SHALL be ignored: fetch_valid=0 next cycle and fetch_data holds its last value.
REQ-024 load_start in RUN SHALL enter LOAD next cycle, set the write pointer and load_count to 0, and clear load_overflow.
REQ-025 If load_start and fetch_req coincide in RUN, the fetch SHALL be served and LOAD entered next cycle.
REQ-026 load_start outside RUN SHALL be ignored.
REQ-027 load_ready SHALL be 1 only in LOAD; a word transfers when load_valid and load_ready are both 1.
REQ-028 Each transfer SHALL write load_data at the write pointer, then increment the pointer and load_count.
REQ-029 A transfer with load_last=1 SHALL return to RUN next cycle.
REQ-030 A transfer at pointer DEPTH-1 with load_last=0 SHALL return to RUN next cycle and set load_overflow.
REQ-031 Words not written by a load SHALL keep their previous contents.
REQ-032 A fetch issued on the first RUN cycle after LOAD SHALL return the newly written data.

Reset
REQ-033 Asserting rst SHALL immediately force state CLEAR, clr_ptr=0, fetch_valid=0, fetch_data=NOP_WORD, load_ready=0, busy=1, load_count=0 and load_overflow=0.
REQ-034 Memory contents SHALL NOT be reset asynchronously; CLEAR initialises them after rst deasserts.
REQ-035 Reset during LOAD or CLEAR SHALL abort that operation and restart CLEAR from address 0.

Structure
REQ-036 Package prog_imem_pkg SHALL hold the state enum type and the default NOP constant.
REQ-037 Storage SHALL be one sub-module, imem_ram: single write port and registered read port, DATA_W x DEPTH, with no reset on the array.
REQ-038 The CLEAR and LOAD write paths SHALL share the imem_ram write port through a mux; the state machine and pointers SHALL stay in prog_instr_mem.

Verification
REQ-039 Reset, then wait 256 cycles -> busy falls on cycle 256; fetch of addresses 0, 5 and 255 returns 0x00000000.
REQ-040 Load 4 words 0xAC410000, 0x8C850000, 0x10A10001, 0x08000001 with last on word 4, then fetch addresses 0-3 back-to-back -> the same 4 words, each 1 cycle after its request; load_count=4.
REQ-041 With DEPTH=16, load 17 words without load_last -> return to RUN after word 16, load_overflow=1, word 17 not accepted (load_ready=0).
REQ-042 Deassert load_valid for 3 cycles mid-load, and fetch_req during LOAD -> no write while load_valid=0, fetch_valid stays 0.
REQ-043 Assert rst after load word 2 -> immediate CLEAR, and a fetch of address 1 after clearing returns 0.
REQ-044 With DEPTH=200, fetch address 220 -> NOP_WORD with fetch_valid=1.
